regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Sequences the single write port of the 32x32 register file (x0 hardwired zero, synchronous write, combinational read). Arbitrates between two writeback requesters: port 0 for the ALU and port 1 for the load unit. Also keeps a pending-write scoreboard so the issue stage can stall on RAW hazards. It sits between the execute/memory stages and register_memory, and drives register_memory's wr_enable, wr_address and wr_data.

Parameters:
XLEN, 32, data width of the register file.
AW, 5, register address width; the number of registers is 2**AW.

Ports:
clk  input  1  rising-edge clock, shared with register_memory.
rst  input  1  asynchronous active-high reset.
wb0_valid  input  1  ALU writeback request.
wb0_rd  input  AW  ALU destination register.
wb0_data  input  XLEN  ALU result.
wb0_ready  output  1  ALU request granted this cycle.
wb1_valid  input  1  load writeback request.
wb1_rd  input  AW  load destination register.
wb1_data  input  XLEN  load data.
wb1_ready  output  1  load request granted this cycle.
claim_valid  input  1  issue stage marks a destination register as pending.
claim_rd  input  AW  register being claimed.
rs1_addr  input  AW  source register 1 query.
rs2_addr  input  AW  source register 2 query.
rs1_busy  output  1  rs1 has a pending write.
rs2_busy  output  1  rs2 has a pending write.
wr_enable  output  1  to register_memory.
wr_address  output  AW  to register_memory.
wr_data  output  XLEN  to register_memory.

Behaviour:
- Reset (async, rst=1): wr_enable=0, wr_address=0, wr_data=0, busy vector=0, last_grant=1. While rst=1, wb0_ready=wb1_ready=0. Reset mid-operation discards any registered write: no wr_enable pulse follows the release of reset.
- Grant (combinational, depends on valids and last_grant only; ready never depends on whether the request is accepted):
  - Only wbN_valid is set -> grant port N.
  - Both are set -> grant the port that was not the last granted (round-robin). The first tie after reset goes to port 0.
  - last_grant updates only on a completed handshake (valid & ready).
- Write stage (registered, latency 1):
  - A handshake at edge k loads wr_address, wr_data and wr_enable from the granted port.
  - wr_enable is high for exactly one cycle. register_memory commits the data at edge k+1.
  - If the granted rd == 0, the handshake still completes but wr_enable stays 0. wr_address and wr_data are don't-care in that case.
  - If there is no handshake, wr_enable=0 and wr_address/wr_data hold their previous values.
  - Throughput is one write per cycle; back-to-back grants give consecutive wr_enable pulses.
- Scoreboard (busy[2**AW], busy[0] always 0):
  - Set: claim_valid & claim_rd != 0 sets busy[claim_rd] at the clock edge.
  - Clear: wr_enable & wr_address == r clears busy[r] at the edge where the write commits.
  - If set and clear target the same register in the same edge, set wins (the new claim survives).
  - A claim of a register that is already busy leaves it busy. The first commit clears it. The issue stage must not claim a busy rd; that case is unchecked here.
  - rsN_busy = busy[rsN_addr] (combinational). It reads 0 for x0.
  - On the commit edge busy is still 1, so the consumer stalls one extra cycle and never reads stale data. No bypass is provided.
- A writeback to a register that is not busy is legal: the write happens and busy is unchanged.

Decomposition:
- Package regfile_pkg holds XLEN, AW, the register-zero constant and the port index constants (PORT_ALU=0, PORT_LSU=1). These are shared with register_memory and the decode stage.
- One sub-module, rr_arbiter2: two requests, a last_grant flop, one-hot grants and an accept input. The scoreboard and write register stay in the top module.

Test Plan:
- Reset: hold rst=1 with wb0_valid=1 -> wb0_ready=0, wr_enable=0, rs1_busy=0. Release rst -> no spurious write.
- Single write: claim x10. Next cycle, wb0 writes rd=10, data=ABCDEFAB. Then wr_enable=1 with wr_address=0A for one cycle, and register_memory data_out_a for x10 reads ABCDEFAB after that edge. rs1_busy(x10) is 1 until that edge, then 0.
- x0 discard: wb1 rd=0, data=EEEEEEEE -> wb1_ready=1, wr_enable stays 0, and register 0 still reads 0. Claim of x0 -> rs1_busy(x0)=0.
- Contention: wb0 (rd=3, 11111111) and wb1 (rd=4, 22222222) both valid for 4 cycles, re-presented after each grant. Grants must be 0,1,0,1 and wr_address must follow 3,4,3,4 on consecutive cycles.
- Set/clear collision: x5 is busy. Its write commits in the same cycle that claim_rd=5 -> rs1_busy(x5)=1 after the edge.
- Mid-operation reset: assert rst in the cycle after a handshake for rd=7 -> no wr_enable pulse, register 7 is unchanged, and all busy bits are 0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg: register file geometry and writeback port indices
// Revision: 1.0
// ============================================================================
package regfile_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  function automatic logic is_reg_zero(input logic [AW-1:0] r);
    return r == REG_ZERO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2: two-way round-robin arbiter with one-hot grants
// Revision: 1.0
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  import regfile_pkg::*;

  logic last_grant_d;
  logic last_grant_q;

  // Grants are gated while reset is held so no requester sees a handshake.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = '0;
      if (last_grant_q == PORT_LSU) begin
        gnt[PORT_ALU] = 1'b1;
      end else begin
        gnt[PORT_LSU] = 1'b1;
      end
    end
    if (rst) begin
      gnt = '0;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = gnt[PORT_LSU] ? PORT_LSU : PORT_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter: writeback arbitration, register-file write stage and
// pending-write scoreboard for RAW stalls
// Revision: 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = regfile_pkg::XLEN,
  parameter int unsigned AW   = regfile_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb1_ready,
  input  logic            claim_valid,
  input  logic [AW-1:0]   claim_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wr_enable,
  output logic [AW-1:0]   wr_address,
  output logic [XLEN-1:0] wr_data
);
  import regfile_pkg::*;

  localparam int unsigned NREGS = 2 ** AW;

  logic [1:0]      w_req;
  logic [1:0]      w_gnt;
  logic            w_accept;
  logic [AW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_data;

  logic            wr_enable_d;
  logic            wr_enable_q;
  logic [AW-1:0]   wr_address_d;
  logic [AW-1:0]   wr_address_q;
  logic [XLEN-1:0] wr_data_d;
  logic [XLEN-1:0] wr_data_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_q;

  always_comb begin
    w_req           = '0;
    w_req[PORT_ALU] = wb0_valid;
    w_req[PORT_LSU] = wb1_valid;
  end

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (w_req),
    .accept (w_accept),
    .gnt    (w_gnt)
  );

  assign w_accept   = |(w_req & w_gnt);
  assign wb0_ready  = w_gnt[PORT_ALU];
  assign wb1_ready  = w_gnt[PORT_LSU];
  assign w_sel_rd   = w_gnt[PORT_LSU] ? wb1_rd   : wb0_rd;
  assign w_sel_data = w_gnt[PORT_LSU] ? wb1_data : wb0_data;

  // A granted write to x0 completes the handshake but never reaches the file.
  always_comb begin
    wr_enable_d  = w_accept && !is_reg_zero(w_sel_rd);
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    if (w_accept) begin
      wr_address_d = w_sel_rd;
      wr_data_d    = w_sel_data;
    end
  end

  // Clear is applied first so a same-edge claim of the committing register survives.
  always_comb begin
    busy_d = busy_q;
    if (wr_enable_q) begin
      busy_d[wr_address_q] = 1'b0;
    end
    if (claim_valid && !is_reg_zero(claim_rd)) begin
      busy_d[claim_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_enable_q  <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      busy_q       <= '0;
    end else begin
      wr_enable_q  <= wr_enable_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_enable  = wr_enable_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign rs1_busy   = busy_q[rs1_addr];
  assign rs2_busy   = busy_q[rs2_addr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter: directed bench with a write scoreboard and a
// behavioural register file fed from the write port
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wb0_valid = 1'b0;
  logic [AW-1:0]   wb0_rd = '0;
  logic [XLEN-1:0] wb0_data = '0;
  logic            wb0_ready;
  logic            wb1_valid = 1'b0;
  logic [AW-1:0]   wb1_rd = '0;
  logic [XLEN-1:0] wb1_data = '0;
  logic            wb1_ready;
  logic            claim_valid = 1'b0;
  logic [AW-1:0]   claim_rd = '0;
  logic [AW-1:0]   rs1_addr = '0;
  logic [AW-1:0]   rs2_addr = '0;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wr_enable;
  logic [AW-1:0]   wr_address;
  logic [XLEN-1:0] wr_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb0_valid   (wb0_valid),
    .wb0_rd      (wb0_rd),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_rd      (wb1_rd),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .claim_valid (claim_valid),
    .claim_rd    (claim_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .wr_enable   (wr_enable),
    .wr_address  (wr_address),
    .wr_data     (wr_data)
  );

  // Stand-in for register_memory: synchronous write, x0 hardwired to zero.
  logic [XLEN-1:0] mem [2**AW] = '{default: '0};
  always @(posedge clk) begin
    if (wr_enable && wr_address != '0) mem[wr_address] <= wr_data;
  end

  logic [AW+XLEN-1:0] exp_q [$];
  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wr_enable === 1'b1) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("write_payload", 64'({wr_address, wr_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic any_busy;

    // Reset held with a request and a claim pending
    rst = 1'b1; wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h1;
    claim_valid = 1'b1; claim_rd = 5'd10; rs1_addr = 5'd10;
    tick(); tick();
    check("rst_wb0_ready", 64'(wb0_ready), 64'd0);
    check("rst_wr_enable", 64'(wr_enable), 64'd0);
    check("rst_wr_address", 64'(wr_address), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_rs1_busy", 64'(rs1_busy), 64'd0);
    rst = 1'b0; wb0_valid = 1'b0; claim_valid = 1'b0;
    tick(); tick();
    check("post_rst_wr_enable", 64'(wr_enable), 64'd0);
    check("post_rst_busy", 64'(rs1_busy), 64'd0);

    // Single write to x10
    claim_valid = 1'b1; claim_rd = 5'd10;
    tick();
    claim_valid = 1'b0;
    check("claim_busy", 64'(rs1_busy), 64'd1);
    wb0_valid = 1'b1; wb0_rd = 5'd10; wb0_data = 32'hABCDEFAB;
    #1;
    check("single_wb0_ready", 64'(wb0_ready), 64'd1);
    check("single_wb1_ready", 64'(wb1_ready), 64'd0);
    push(5'd10, 32'hABCDEFAB);
    tick();
    wb0_valid = 1'b0;
    check("single_wr_enable", 64'(wr_enable), 64'd1);
    check("single_wr_address", 64'(wr_address), 64'hA);
    check("single_busy_precommit", 64'(rs1_busy), 64'd1);
    tick();
    check("single_pulse_width", 64'(wr_enable), 64'd0);
    check("single_busy_cleared", 64'(rs1_busy), 64'd0);
    check("single_mem", 64'(mem[10]), 64'hABCDEFAB);
    check("hold_address", 64'(wr_address), 64'hA);
    check("hold_data", 64'(wr_data), 64'hABCDEFAB);

    // Write to x0 completes but is discarded
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'hEEEEEEEE;
    #1;
    check("x0_wb1_ready", 64'(wb1_ready), 64'd1);
    check("x0_wb0_ready", 64'(wb0_ready), 64'd0);
    tick();
    wb1_valid = 1'b0;
    check("x0_wr_enable", 64'(wr_enable), 64'd0);
    claim_valid = 1'b1; claim_rd = 5'd0;
    tick();
    claim_valid = 1'b0; rs1_addr = 5'd0;
    #1;
    check("x0_claim_busy", 64'(rs1_busy), 64'd0);

    // Contention: round-robin 0,1,0,1
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h11111111;
    wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("tie%0d_grant", i), 64'({wb1_ready, wb0_ready}),
            (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i % 2 == 0) push(5'd3, 32'h11111111);
      else            push(5'd4, 32'h22222222);
      tick();
      check($sformatf("tie%0d_wr_enable", i), 64'(wr_enable), 64'd1);
      check($sformatf("tie%0d_wr_address", i), 64'(wr_address), (i % 2 == 0) ? 64'd3 : 64'd4);
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick();
    check("tie_end_wr_enable", 64'(wr_enable), 64'd0);

    // Set and clear of x5 on the same edge: the claim wins
    claim_valid = 1'b1; claim_rd = 5'd5;
    tick();
    claim_valid = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check("coll_busy_set", 64'(rs1_busy), 64'd1);
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'h55555555;
    push(5'd5, 32'h55555555);
    tick();
    wb0_valid = 1'b0; claim_valid = 1'b1; claim_rd = 5'd5;
    check("coll_wr_enable", 64'(wr_enable), 64'd1);
    tick();
    claim_valid = 1'b0;
    check("coll_rs1_busy", 64'(rs1_busy), 64'd1);
    check("coll_rs2_busy", 64'(rs2_busy), 64'd1);
    wb0_valid = 1'b1; wb0_data = 32'h5A5A5A5A;
    push(5'd5, 32'h5A5A5A5A);
    tick();
    wb0_valid = 1'b0;
    tick();
    check("coll_cleared", 64'(rs1_busy), 64'd0);
    check("coll_mem", 64'(mem[5]), 64'h5A5A5A5A);

    // Reset right after a handshake for x7 drops the write
    claim_valid = 1'b1; claim_rd = 5'd7;
    tick();
    claim_valid = 1'b0; rs1_addr = 5'd7;
    #1;
    check("midrst_claim", 64'(rs1_busy), 64'd1);
    wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77777777;
    tick();
    rst = 1'b1; wb0_valid = 1'b0;
    #1;
    check("midrst_wr_enable", 64'(wr_enable), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("midrst_no_pulse", 64'(wr_enable), 64'd0);
    tick();
    check("midrst_mem7", 64'(mem[7]), 64'd0);
    any_busy = 1'b0;
    for (int r = 0; r < 32; r++) begin
      rs1_addr = AW'(r);
      #1;
      any_busy = any_busy | rs1_busy;
    end
    check("midrst_busy_all", 64'(any_busy), 64'd0);

    // First tie after reset goes to port 0
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h33333333;
    wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h44444444;
    #1;
    check("rst_tie_grant", 64'({wb1_ready, wb0_ready}), 64'd1);
    push(5'd3, 32'h33333333);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick(); tick();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
